// File: rtl/tmds_decoder.sv
`default_nettype none
//==============================================================================
// Module   : tmds_decoder
// Brief    : TMDS channel decoder with bit-slip word alignment on DVI control
//            tokens; emits pixel byte or control code plus blanking flag.
// Revision : 1.0 - initial release
//==============================================================================
module tmds_decoder #(
    parameter int P_LOCK_TOKENS  = 8,
    parameter int P_DWELL_CYCLES = 64,
    parameter int P_LOSS_CYCLES  = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_symbol,
    output logic [7:0] o_data,
    output logic [1:0] o_control_data,
    output logic       o_blanking,
    output logic       o_valid,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    localparam int c_TOK_W   = (P_LOCK_TOKENS  > 1) ? $clog2(P_LOCK_TOKENS)  : 1;
    localparam int c_DWELL_W = (P_DWELL_CYCLES > 1) ? $clog2(P_DWELL_CYCLES) : 1;
    localparam int c_LOSS_W  = (P_LOSS_CYCLES  > 1) ? $clog2(P_LOSS_CYCLES)  : 1;

    localparam logic [c_TOK_W-1:0]   c_TOK_LAST   = c_TOK_W'(P_LOCK_TOKENS - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(P_DWELL_CYCLES - 1);
    localparam logic [c_LOSS_W-1:0]  c_LOSS_LAST  = c_LOSS_W'(P_LOSS_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_q,   state_d;
    logic [3:0]           offset_q,  offset_d;
    logic [c_TOK_W-1:0]   tok_cnt_q, tok_cnt_d;
    logic [c_DWELL_W-1:0] dwell_q,   dwell_d;
    logic [c_LOSS_W-1:0]  loss_q,    loss_d;
    logic [9:0]           prev_q,    prev_d;
    logic [7:0]           data_q,    data_d;
    logic [1:0]           ctrl_q,    ctrl_d;
    logic                 blank_q,   blank_d;
    logic                 locked_q,  locked_d;

    logic [18:0] w_window;
    logic [9:0]  w_sym;
    logic        w_is_tok;
    logic [1:0]  w_tok_code;
    logic [7:0]  w_d;
    logic [7:0]  w_dec;
    logic [3:0]  w_offset_inc;
    logic        w_locked_nx;

    // Offsets only reach 9, so the top bit of the newest word never lands in the window.
    always_comb begin
        w_window = {i_symbol[8:0], prev_q};
        w_sym    = w_window[9:0];
        for (int k = 0; k < 10; k++) begin
            if (offset_q == 4'(k)) begin
                w_sym = w_window[k +: 10];
            end
        end
    end

    always_comb begin
        w_is_tok   = 1'b1;
        w_tok_code = 2'b00;
        case (w_sym)
            10'h354: w_tok_code = 2'b00;
            10'h0AB: w_tok_code = 2'b01;
            10'h154: w_tok_code = 2'b10;
            10'h2AB: w_tok_code = 2'b11;
            default: w_is_tok   = 1'b0;
        endcase
    end

    always_comb begin
        w_d      = w_sym[9] ? ~w_sym[7:0] : w_sym[7:0];
        w_dec    = '0;
        w_dec[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            w_dec[i] = w_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        tok_cnt_d    = tok_cnt_q;
        dwell_d      = dwell_q;
        loss_d       = loss_q;
        w_offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        case (state_q)
            ST_SEARCH: begin
                // A completed token run takes priority over a simultaneous dwell expiry.
                if (w_is_tok && (tok_cnt_q == c_TOK_LAST)) begin
                    state_d   = ST_LOCKED;
                    tok_cnt_d = '0;
                    dwell_d   = '0;
                    loss_d    = '0;
                end else if (dwell_q == c_DWELL_LAST) begin
                    offset_d  = w_offset_inc;
                    dwell_d   = '0;
                    tok_cnt_d = '0;
                end else begin
                    dwell_d   = dwell_q + c_DWELL_W'(1);
                    tok_cnt_d = w_is_tok ? tok_cnt_q + c_TOK_W'(1) : '0;
                end
            end
            ST_LOCKED: begin
                if (w_is_tok) begin
                    loss_d = '0;
                end else if (loss_q == c_LOSS_LAST) begin
                    state_d   = ST_SEARCH;
                    offset_d  = w_offset_inc;
                    loss_d    = '0;
                    tok_cnt_d = '0;
                    dwell_d   = '0;
                end else begin
                    loss_d = loss_q + c_LOSS_W'(1);
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Output stage follows the next state so lock status stays aligned with the symbol it describes.
    always_comb begin
        prev_d      = i_symbol;
        w_locked_nx = (state_d == ST_LOCKED);
        locked_d    = w_locked_nx;
        data_d      = 8'h00;
        ctrl_d      = ctrl_q;
        blank_d     = 1'b1;
        if (!w_locked_nx) begin
            ctrl_d = 2'b00;
        end else if (w_is_tok) begin
            ctrl_d = w_tok_code;
        end else begin
            blank_d = 1'b0;
            data_d  = w_dec;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_SEARCH;
            offset_q  <= 4'd0;
            tok_cnt_q <= '0;
            dwell_q   <= '0;
            loss_q    <= '0;
            prev_q    <= 10'd0;
            data_q    <= 8'h00;
            ctrl_q    <= 2'b00;
            blank_q   <= 1'b1;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            tok_cnt_q <= tok_cnt_d;
            dwell_q   <= dwell_d;
            loss_q    <= loss_d;
            prev_q    <= prev_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            blank_q   <= blank_d;
            locked_q  <= locked_d;
        end
    end

    assign o_data         = data_q;
    assign o_control_data = ctrl_q;
    assign o_blanking     = blank_q;
    assign o_valid        = locked_q;
    assign o_locked       = locked_q;
    assign o_offset       = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
//==============================================================================
// Module   : tb_tmds_decoder
// Brief    : Self-checking bench: DVI encoder + bit rotator drive the decoder,
//            a behavioural model predicts every output cycle.
// Revision : 1.0 - initial release
//==============================================================================
module tb_tmds_decoder;

    localparam int LOCK  = 8;
    localparam int DWELL = 16;
    localparam int LOSS  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sym;
    logic [7:0] o_data;
    logic [1:0] o_control_data;
    logic       o_blanking;
    logic       o_valid;
    logic       o_locked;
    logic [3:0] o_offset;

    tmds_decoder #(
        .P_LOCK_TOKENS (LOCK),
        .P_DWELL_CYCLES(DWELL),
        .P_LOSS_CYCLES (LOSS)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_symbol      (sym),
        .o_data        (o_data),
        .o_control_data(o_control_data),
        .o_blanking    (o_blanking),
        .o_valid       (o_valid),
        .o_locked      (o_locked),
        .o_offset      (o_offset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [9:0] tok_word(input int c);
        case (c)
            0:       return 10'h354;
            1:       return 10'h0AB;
            2:       return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    // Reference model state
    bit         m_locked;
    int         m_off, m_tok, m_dwell, m_loss;
    logic [9:0] m_prev;
    logic [7:0] e_data;
    logic [1:0] e_ctrl;
    bit         e_blank, e_locked;

    task automatic model_step(input bit r, input logic [9:0] s);
        logic [19:0] win;
        logic [9:0]  q;
        logic [7:0]  d;
        int          code;
        if (r) begin
            m_locked = 0; m_off = 0; m_tok = 0; m_dwell = 0; m_loss = 0; m_prev = '0;
            e_data = 0; e_ctrl = 0; e_blank = 1; e_locked = 0;
            return;
        end
        win  = {s, m_prev};
        q    = 10'(win >> m_off);
        code = -1;
        for (int i = 0; i < 4; i++) if (q == tok_word(i)) code = i;
        if (!m_locked) begin
            if (code >= 0 && m_tok == LOCK - 1) begin
                m_locked = 1; m_tok = 0; m_dwell = 0; m_loss = 0;
            end else if (m_dwell == DWELL - 1) begin
                m_off = (m_off + 1) % 10; m_dwell = 0; m_tok = 0;
            end else begin
                m_dwell++;
                m_tok = (code >= 0) ? m_tok + 1 : 0;
            end
        end else begin
            if (code >= 0) m_loss = 0;
            else if (m_loss == LOSS - 1) begin
                m_locked = 0; m_off = (m_off + 1) % 10; m_loss = 0; m_tok = 0; m_dwell = 0;
            end else m_loss++;
        end
        e_locked = m_locked;
        e_data   = 0;
        e_blank  = 1;
        if (!m_locked) e_ctrl = 0;
        else if (code >= 0) e_ctrl = 2'(code);
        else begin
            e_blank = 0;
            d       = q[9] ? ~q[7:0] : q[7:0];
            e_data  = d ^ (d << 1) ^ (q[8] ? 8'h00 : 8'hFE);
        end
        m_prev = s;
    endtask

    task automatic cycle(input bit r, input logic [9:0] s);
        @(negedge clk);
        rst = r;
        sym = s;
        model_step(r, s);
        @(posedge clk);
        #1;
        check_eq("locked", 32'(o_locked), 32'(e_locked));
        check_eq("valid", 32'(o_valid), 32'(e_locked));
        check_eq("offset", 32'(o_offset), 32'(m_off));
        check_eq("blanking", 32'(o_blanking), 32'(e_blank));
        check_eq("ctrl", 32'(o_control_data), 32'(e_ctrl));
        check_eq("data", 32'(o_data), 32'(e_data));
    endtask

    // DVI encoder plus bit rotator
    int         disp;
    int         rot;
    logic [9:0] enc_prev;
    int         cur_kind, prior_kind;
    logic [7:0] cur_byte, prior_byte;
    logic [1:0] cur_code, prior_code;

    task automatic encode(input bit is_ctrl, input logic [1:0] c, input logic [7:0] b,
                          output logic [9:0] w);
        logic [8:0] qm;
        int         n1, n1q, n0q;
        if (is_ctrl) begin
            w    = tok_word(int'(c));
            disp = 0;
            return;
        end
        n1 = $countones(b);
        qm[0] = b[0];
        if (n1 > 4 || (n1 == 4 && !b[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            w    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp = disp + (qm[8] ? (n1q - n0q) : (n0q - n1q));
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            w    = {1'b1, qm[8], ~qm[7:0]};
            disp = disp + 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            w    = {1'b0, qm[8], qm[7:0]};
            disp = disp - 2 * int'(!qm[8]) + n1q - n0q;
        end
    endtask

    task automatic send(input bit r, input bit is_ctrl, input logic [1:0] c, input logic [7:0] b);
        logic [9:0]  w;
        logic [19:0] pair;
        encode(is_ctrl, c, b, w);
        pair       = {w, enc_prev};
        enc_prev   = w;
        prior_kind = cur_kind;
        prior_byte = cur_byte;
        prior_code = cur_code;
        cur_kind   = is_ctrl ? 2 : 1;
        cur_byte   = b;
        cur_code   = c;
        cycle(r, 10'(pair >> (10 - rot)));
        if (r) cur_kind = 0;
        else if (e_locked && m_off == rot && prior_kind != 0) begin
            if (prior_kind == 1) begin
                check_eq("src_data", 32'(o_data), 32'(prior_byte));
                check_eq("src_blank", 32'(o_blanking), 32'd0);
            end else begin
                check_eq("src_ctrl", 32'(o_control_data), 32'(prior_code));
                check_eq("src_blank", 32'(o_blanking), 32'd1);
            end
        end
    endtask

    task automatic new_stream(input int r);
        rot = r; enc_prev = '0; disp = 0; cur_kind = 0;
    endtask

    initial begin
        rst = 1'b1;
        sym = '0;
        new_stream(0);
        cycle(1, 10'h000);
        cycle(1, 10'h3FF);
        check_eq("rst_blank", 32'(o_blanking), 32'd1);
        check_eq("rst_locked", 32'(o_locked), 32'd0);

        // Aligned stream
        for (int i = 0; i < 20; i++) begin
            send(0, 1, 2'b00, 8'h00);
            if (i == 9) begin
                check_eq("lock_by_10", 32'(o_locked), 32'd1);
                check_eq("lock_off0", 32'(o_offset), 32'd0);
            end
        end
        for (int i = 0; i < 20; i++) send(0, 0, 2'b00, (i % 2 == 0) ? 8'hFF : 8'h00);

        // Control token sequence
        for (int i = 0; i < 4; i++) send(0, 1, 2'(i), 8'h00);
        send(0, 0, 2'b00, 8'h5A);

        // Random traffic while locked
        for (int i = 0; i < 120; i++) begin
            if (i % 16 == 15 || $urandom_range(0, 7) == 0)
                send(0, 1, 2'($urandom_range(0, 3)), 8'h00);
            else
                send(0, 0, 2'b00, 8'($urandom));
        end

        // Loss of lock
        send(0, 1, 2'b01, 8'h00);
        for (int j = 0; j < 40; j++) begin
            send(0, 0, 2'b00, 8'($urandom));
            if (j == 31) check_eq("loss_still", 32'(o_locked), 32'd1);
            if (j == 32) begin
                check_eq("loss_locked", 32'(o_locked), 32'd0);
                check_eq("loss_valid", 32'(o_valid), 32'd0);
                check_eq("loss_blank", 32'(o_blanking), 32'd1);
                check_eq("loss_off", 32'(o_offset), 32'd1);
            end
        end

        // Rotated stream by 7
        new_stream(7);
        send(1, 1, 2'b00, 8'h00);
        for (int i = 0; i < 200; i++) begin
            send(0, 1, 2'b00, 8'h00);
            if (i == 100) check_eq("rot_step6", 32'(o_offset), 32'd6);
        end
        check_eq("rot_locked", 32'(o_locked), 32'd1);
        check_eq("rot_off7", 32'(o_offset), 32'd7);
        for (int i = 0; i < 30; i++) send(0, 0, 2'b00, 8'h01 << (i % 8));

        // Lock on the dwell-expiry cycle
        new_stream(0);
        send(1, 1, 2'b00, 8'h00);
        for (int c = 0; c < 18; c++) begin
            if (c < 7) send(0, 0, 2'b00, 8'($urandom));
            else send(0, 1, 2'b00, 8'h00);
            if (c == 14) check_eq("bnd_pre", 32'(o_locked), 32'd0);
            if (c == 15) begin
                check_eq("bnd_lock", 32'(o_locked), 32'd1);
                check_eq("bnd_off", 32'(o_offset), 32'd0);
            end
        end

        // Offset wrap 9 -> 0
        new_stream(0);
        send(1, 1, 2'b00, 8'h00);
        for (int c = 0; c < 170; c++) begin
            send(0, 0, 2'b00, 8'($urandom));
            if (c == 150) check_eq("wrap_off9", 32'(o_offset), 32'd9);
            if (c == 160) check_eq("wrap_off0", 32'(o_offset), 32'd0);
        end

        // Reset while locked at offset 5
        new_stream(5);
        send(1, 1, 2'b00, 8'h00);
        for (int i = 0; i < 100; i++) send(0, 1, 2'b00, 8'h00);
        check_eq("r5_locked", 32'(o_locked), 32'd1);
        check_eq("r5_off", 32'(o_offset), 32'd5);
        for (int i = 0; i < 5; i++) send(0, 0, 2'b00, 8'($urandom));
        send(1, 0, 2'b00, 8'hC3);
        check_eq("mid_locked", 32'(o_locked), 32'd0);
        check_eq("mid_off", 32'(o_offset), 32'd0);
        check_eq("mid_blank", 32'(o_blanking), 32'd1);
        check_eq("mid_data", 32'(o_data), 32'd0);
        for (int i = 0; i < 100; i++) send(0, 1, 2'b00, 8'h00);
        check_eq("relock", 32'(o_locked), 32'd1);
        check_eq("relock_off", 32'(o_offset), 32'd5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
